// File: rtl/alu_op_sequencer.sv
// ALU operation sequencer: accepts requests over valid/ready and drives a
// combinational ALU. Single-pass ops take one ALU cycle. MUL and DIV are
// iterated WIDTH times through the ALU's ADD/SUB (shift-add / restoring).
module alu_op_sequencer #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [SEL_W-1:0] req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_carry,
  output logic             resp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carry
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [SEL_W-1:0] OP_ADD = SEL_W'(0);
  localparam logic [SEL_W-1:0] OP_SUB = SEL_W'(1);
  localparam logic [SEL_W-1:0] OP_MUL = SEL_W'(2);
  localparam logic [SEL_W-1:0] OP_DIV = SEL_W'(3);
  localparam logic [SEL_W-1:0] OP_BAD0 = SEL_W'(14);
  localparam logic [SEL_W-1:0] OP_BAD1 = SEL_W'(15);

  typedef enum logic [2:0] {IDLE, EXEC, MUL_LOOP, DIV_LOOP, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [SEL_W-1:0]   op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  // work: MUL accumulator / DIV partial remainder
  // mc:   MUL shifted multiplicand
  // sh:   MUL multiplier (shifted right) / DIV dividend-quotient (shifted left)
  logic [WIDTH-1:0]   work;
  logic [WIDTH-1:0]   mc;
  logic [WIDTH-1:0]   sh;

  logic               accept;
  logic               last_iter;
  logic               illegal;
  logic               div_zero;
  logic [WIDTH-1:0]   p;
  logic               p_ge_b;

  assign req_ready = (state == IDLE) && !reset;
  assign accept    = req_valid && req_ready;
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));
  assign illegal   = (op_q == OP_BAD0) || (op_q == OP_BAD1);
  assign div_zero  = (op_q == OP_DIV) && (b_q == '0);
  assign p         = {work[WIDTH-2:0], sh[WIDTH-1]};
  assign p_ge_b    = (p >= b_q);

  // Drive ALU inputs from the current state; idle/done/no-op cycles present zeros.
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_sel = OP_ADD;
    case (state)
      EXEC: begin
        if (!illegal && !div_zero) begin
          alu_a   = a_q;
          alu_b   = b_q;
          alu_sel = op_q;
        end
      end
      MUL_LOOP: begin
        alu_a   = work;
        alu_b   = mc;
        alu_sel = OP_ADD;
      end
      DIV_LOOP: begin
        alu_a   = p;
        alu_b   = b_q;
        alu_sel = OP_SUB;
      end
      default: ;
    endcase
  end

  // Control FSM: sequencing, iteration count and the registered response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      resp_valid  <= 1'b0;
      resp_result <= '0;
      resp_carry  <= 1'b0;
      resp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (accept) begin
            if (req_op == OP_MUL)
              state <= MUL_LOOP;
            else if ((req_op == OP_DIV) && (req_b != '0))
              state <= DIV_LOOP;
            else
              state <= EXEC;
          end
        end
        EXEC: begin
          resp_valid  <= 1'b1;
          resp_result <= illegal ? '0 : (div_zero ? '1 : alu_out);
          resp_carry  <= (illegal || div_zero) ? 1'b0 : alu_carry;
          resp_err    <= illegal || div_zero;
          state       <= DONE;
        end
        MUL_LOOP: begin
          cnt <= cnt + 1'b1;
          if (last_iter) begin
            resp_valid  <= 1'b1;
            resp_result <= sh[0] ? alu_out : work;
            resp_carry  <= 1'b0;
            resp_err    <= 1'b0;
            state       <= DONE;
          end
        end
        DIV_LOOP: begin
          cnt <= cnt + 1'b1;
          if (last_iter) begin
            resp_valid  <= 1'b1;
            resp_result <= {sh[WIDTH-2:0], p_ge_b};
            resp_carry  <= 1'b0;
            resp_err    <= 1'b0;
            state       <= DONE;
          end
        end
        DONE: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath registers: operands latch on accept, loop state advances per iteration.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q <= req_op;
      a_q  <= req_a;
      b_q  <= req_b;
      work <= '0;
      mc   <= req_a;
      sh   <= (req_op == OP_MUL) ? req_b : req_a;
    end else if (state == MUL_LOOP) begin
      if (sh[0])
        work <= alu_out;
      mc <= mc << 1;
      sh <= sh >> 1;
    end else if (state == DIV_LOOP) begin
      work <= p_ge_b ? alu_out : p;
      sh   <= {sh[WIDTH-2:0], p_ge_b};
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a small behavioural ALU attached.
module tb_alu_op_sequencer;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_result;
  logic        resp_carry;
  logic        resp_err;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_sel;
  logic [31:0] alu_out;
  logic        alu_carry;

  int checks = 0;
  int failures = 0;

  alu_op_sequencer #(.WIDTH(32), .SEL_W(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_carry(resp_carry), .resp_err(resp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: the subset of operations this bench exercises.
  logic [32:0] alu_wide;
  always_comb begin
    alu_wide = 33'd0;
    case (alu_sel)
      4'b0000: alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
      4'b0001: alu_wide = {1'b0, alu_a} - {1'b0, alu_b};
      4'b0100: alu_wide = {1'b0, alu_a & alu_b};
      4'b1000: alu_wide = {1'b0, alu_b[30:0], alu_b[31]};
      4'b1101: alu_wide = {1'b0, ~(alu_a & alu_b)};
      default: alu_wide = 33'd0;
    endcase
  end
  assign alu_out   = alu_wide[31:0];
  assign alu_carry = alu_wide[32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one request and wait (bounded) for resp_valid; lat counts cycles from accept.
  task automatic run_req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [3:0] sel_t1);
    int w;
    @(negedge clk);
    w = 0;
    while (!req_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("req_ready_before_req", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_op = op;
    req_a = a;
    req_b = b;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    sel_t1 = 4'hx;
    while (!resp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
      if (lat == 1) sel_t1 = alu_sel;
    end
  endtask

  // Complete the response handshake; req_ready must return the following cycle.
  task automatic handshake(input string name);
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    check({name, "_valid_clear"}, {31'd0, resp_valid}, 32'd0);
    check({name, "_ready_back"}, {31'd0, req_ready}, 32'd1);
  endtask

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        carry;
    logic        err;
    int          lat;
    logic [3:0]  sel;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int lat;
    logic [3:0] sel1;
    logic [31:0] held;
    logic saw_valid;

    vecs.push_back('{"add_5_3",     4'b0000, 32'd5,          32'd3,          32'h0000_0008, 1'b0, 1'b0, 2,  4'b0000});
    vecs.push_back('{"add_wrap",    4'b0000, 32'hFFFF_FFFF,  32'd1,          32'h0000_0000, 1'b1, 1'b0, 2,  4'b0000});
    vecs.push_back('{"sub_9_4",     4'b0001, 32'd9,          32'd4,          32'h0000_0005, 1'b0, 1'b0, 2,  4'b0001});
    vecs.push_back('{"sub_borrow",  4'b0001, 32'd3,          32'd5,          32'hFFFF_FFFE, 1'b1, 1'b0, 2,  4'b0001});
    vecs.push_back('{"and",         4'b0100, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000, 1'b0, 1'b0, 2,  4'b0100});
    vecs.push_back('{"rol",         4'b1000, 32'h1234_5678,  32'h8000_0001,  32'h0000_0003, 1'b0, 1'b0, 2,  4'b1000});
    vecs.push_back('{"nand",        4'b1101, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000, 1'b0, 1'b0, 2,  4'b1101});
    vecs.push_back('{"illegal_e",   4'b1110, 32'd7,          32'd9,          32'h0000_0000, 1'b0, 1'b1, 2,  4'b0000});
    vecs.push_back('{"illegal_f",   4'b1111, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000, 1'b0, 1'b1, 2,  4'b0000});
    vecs.push_back('{"div_by_zero", 4'b0011, 32'd5,          32'd0,          32'hFFFF_FFFF, 1'b0, 1'b1, 2,  4'b0000});
    vecs.push_back('{"mul_basic",   4'b0010, 32'h0001_0003,  32'h0000_0010,  32'h0010_0030, 1'b0, 1'b0, 33, 4'b0000});
    vecs.push_back('{"mul_ovf",     4'b0010, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE, 1'b0, 1'b0, 33, 4'b0000});
    vecs.push_back('{"mul_7_6",     4'b0010, 32'd7,          32'd6,          32'd42,        1'b0, 1'b0, 33, 4'b0000});
    vecs.push_back('{"mul_top",     4'b0010, 32'h8000_0001,  32'h8000_0001,  32'h0000_0001, 1'b0, 1'b0, 33, 4'b0000});
    vecs.push_back('{"div_100_7",   4'b0011, 32'd100,        32'd7,          32'd14,        1'b0, 1'b0, 33, 4'b0001});
    vecs.push_back('{"div_max_1",   4'b0011, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF, 1'b0, 1'b0, 33, 4'b0001});
    vecs.push_back('{"div_small",   4'b0011, 32'd7,          32'd100,        32'd0,         1'b0, 1'b0, 33, 4'b0001});
    vecs.push_back('{"div_big",     4'b0011, 32'hFFFF_FFFF,  32'h0001_0000,  32'h0000_FFFF, 1'b0, 1'b0, 33, 4'b0001});

    reset = 1'b1;
    req_valid = 1'b0;
    req_op = 4'd0;
    req_a = 32'd0;
    req_b = 32'd0;
    resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_result", resp_result, 32'd0);
    check("rst_resp_err", {31'd0, resp_err}, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_sel", {28'd0, alu_sel}, 32'd0);
    reset = 1'b0;
    #1 check("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

    foreach (vecs[i]) begin
      run_req(vecs[i].op, vecs[i].a, vecs[i].b, lat, sel1);
      check({vecs[i].name, "_latency"}, lat, vecs[i].lat);
      check({vecs[i].name, "_result"}, resp_result, vecs[i].res);
      check({vecs[i].name, "_carry"}, {31'd0, resp_carry}, {31'd0, vecs[i].carry});
      check({vecs[i].name, "_err"}, {31'd0, resp_err}, {31'd0, vecs[i].err});
      check({vecs[i].name, "_sel_t1"}, {28'd0, sel1}, {28'd0, vecs[i].sel});
      check({vecs[i].name, "_sel_done"}, {28'd0, alu_sel}, 32'd0);
      check({vecs[i].name, "_alu_a_done"}, alu_a, 32'd0);
      handshake(vecs[i].name);
    end

    // Backpressure: response held for 5 cycles, no new request accepted meanwhile.
    run_req(4'b0000, 32'd5, 32'd3, lat, sel1);
    check("bp_latency", lat, 2);
    held = resp_result;
    check("bp_result", held, 32'd8);
    req_valid = 1'b1;
    req_op = 4'b0001;
    req_a = 32'd100;
    req_b = 32'd1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_valid_hold", {31'd0, resp_valid}, 32'd1);
      check("bp_result_hold", resp_result, 32'd8);
      check("bp_req_ready_low", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    handshake("bp");

    // Reset during MUL iteration 10: no response may ever appear.
    @(negedge clk);
    req_valid = 1'b1;
    req_op = 4'b0010;
    req_a = 32'd3;
    req_b = 32'd5;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (11) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_req_ready_in_reset", {31'd0, req_ready}, 32'd0);
    reset = 1'b0;
    #1 check("midrst_req_ready_after", {31'd0, req_ready}, 32'd1);
    check("midrst_alu_sel", {28'd0, alu_sel}, 32'd0);
    saw_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (resp_valid) saw_valid = 1'b1;
    end
    check("midrst_no_resp", {31'd0, saw_valid}, 32'd0);

    run_req(4'b0001, 32'd9, 32'd4, lat, sel1);
    check("after_rst_sub_latency", lat, 2);
    check("after_rst_sub_result", resp_result, 32'd5);
    handshake("after_rst_sub");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
